// File: rtl/gyro_regbank_pkg.sv
// Shared types and helpers for the gyro AXI4-Lite register bank.
package gyro_regbank_pkg;

  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {REG_CTRL, REG_STATUS, REG_SAMPLE, REG_NONE} reg_kind_t;

  localparam int ST_CNT_W   = 16;
  localparam int ST_OVR_BIT = 16;
  localparam int ST_IRQ_BIT = 17;

  // Word map: control block, one status word, then the sample channels.
  function automatic reg_kind_t reg_kind(input int unsigned idx, input int unsigned num_ctrl,
                                         input int unsigned num_ch);
    if (idx < num_ctrl) return REG_CTRL;
    if (idx == num_ctrl) return REG_STATUS;
    if (idx <= num_ctrl + num_ch) return REG_SAMPLE;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/gyro_axil_regbank_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the register bank (slave).
interface gyro_axil_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gyro_sample_latch.sv
// Gyro sample registers, capture counter, overrun and data-ready pending flag.
// Pending flag only exists with GYRO_REGBANK_IRQ_EN defined.
module gyro_sample_latch
  import gyro_regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 6,
  parameter int NUM_CTRL = 4,
  parameter int NUM_CH   = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic                       freeze,
  input  logic                       rd_stb,
  input  logic [IDX_W-1:0]           rd_idx,
  input  logic                       irq_clr,
  output logic [DATA_W-1:0]          status_word,
  output logic [DATA_W-1:0]          rd_sample,
  output logic                       irq_pend
);

  localparam logic [IDX_W-1:0] ST_IDX   = IDX_W'(NUM_CTRL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CTRL + NUM_CH);

  logic [NUM_CH-1:0][SAMPLE_W-1:0] samp_q, samp_d;
  logic [ST_CNT_W-1:0]             cnt_q, cnt_d;
  logic                            unread_q, unread_d;
  logic                            overrun_q, overrun_d;
  logic                            capture;

  assign capture = sample_valid && !freeze;

  // Capture wins over a same-cycle read so fresh data is never reported as consumed.
  always_comb begin
    samp_d    = samp_q;
    cnt_d     = cnt_q;
    unread_d  = unread_q;
    overrun_d = overrun_q;
    if (capture) samp_d = sample_data;
    if (sample_valid) cnt_d = cnt_q + ST_CNT_W'(1);
    if (capture) unread_d = 1'b1;
    else if (rd_stb && rd_idx == LAST_IDX) unread_d = 1'b0;
    if (sample_valid && unread_q) overrun_d = 1'b1;
    else if (rd_stb && rd_idx == ST_IDX) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q    <= '0;
      cnt_q     <= '0;
      unread_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      samp_q    <= samp_d;
      cnt_q     <= cnt_d;
      unread_q  <= unread_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef GYRO_REGBANK_IRQ_EN
  logic irq_pend_q, irq_pend_d;
  always_comb irq_pend_d = capture ? 1'b1 : (irq_clr ? 1'b0 : irq_pend_q);
  always_ff @(posedge clk) begin
    if (rst) irq_pend_q <= 1'b0;
    else     irq_pend_q <= irq_pend_d;
  end
  assign irq_pend = irq_pend_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq_pend = 1'b0;
`endif

  always_comb begin
    status_word                 = '0;
    status_word[ST_CNT_W-1:0]   = cnt_q;
    status_word[ST_OVR_BIT]     = overrun_q;
    status_word[ST_IRQ_BIT]     = irq_pend;
  end

  always_comb begin
    rd_sample = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (rd_idx == IDX_W'(NUM_CTRL + 1 + k)) rd_sample = DATA_W'($signed(samp_q[k]));
  end

endmodule

// File: rtl/gyro_axil_regbank.sv
// AXI4-Lite register bank: NUM_CTRL RW control regs, status, NUM_CH RO gyro samples.
// Define GYRO_REGBANK_IRQ_EN to enable the data-ready interrupt and W1C status bit.
module gyro_axil_regbank
  import gyro_regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int NUM_CTRL = 4,
  parameter int NUM_CH   = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_areset,
  gyro_axil_regbank_if.slave         s00_axi,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  output logic [NUM_CTRL*DATA_W-1:0] ctrl_q,
  output logic                       irq
);

  localparam int IDX_W = ADDR_W - 2;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("gyro_axil_regbank supports DATA_W = 32 only");
  end

  wr_state_t                       wr_state_q, wr_state_d;
  rd_state_t                       rd_state_q, rd_state_d;
  logic                            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]                aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]               wdata_q, wdata_d;
  logic [DATA_W/8-1:0]             wstrb_q, wstrb_d;
  resp_t                           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0]               rdata_q, rdata_d;
  logic [NUM_CTRL-1:0][DATA_W-1:0] ctrl_reg_q, ctrl_d;

  logic                aw_rdy, w_rdy, ar_rdy, aw_fire, w_fire, ar_fire, commit;
  logic [IDX_W-1:0]    c_idx, r_idx;
  logic [DATA_W-1:0]   c_data, status_word, rd_sample;
  logic [DATA_W/8-1:0] c_strb;
  reg_kind_t           c_kind, r_kind;
  logic                irq_clr, irq_pend;

  // Commit uses the live channel for whichever of AW/W handshakes on the committing edge.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_reg_q;
    commit     = 1'b0;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    c_idx      = aw_held_q ? aw_idx_q : s00_axi.awaddr[ADDR_W-1:2];
    c_data     = w_held_q ? wdata_q : s00_axi.wdata;
    c_strb     = w_held_q ? wstrb_q : s00_axi.wstrb;
    c_kind     = reg_kind(32'(c_idx), NUM_CTRL, NUM_CH);
    if (wr_state_q == W_IDLE) begin
      aw_rdy = !aw_held_q && !s00_axi_areset;
      w_rdy  = !w_held_q && !s00_axi_areset;
    end
    aw_fire = s00_axi.awvalid && aw_rdy;
    w_fire  = s00_axi.wvalid && w_rdy;
    if (wr_state_q == W_IDLE) begin
      if (aw_fire) begin
        aw_held_d = 1'b1;
        aw_idx_d  = s00_axi.awaddr[ADDR_W-1:2];
      end
      if (w_fire) begin
        w_held_d = 1'b1;
        wdata_d  = s00_axi.wdata;
        wstrb_d  = s00_axi.wstrb;
      end
      if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
        commit     = 1'b1;
        wr_state_d = W_RESP;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        bresp_d    = SLVERR;
        if (c_kind == REG_CTRL) bresp_d = OKAY;
`ifdef GYRO_REGBANK_IRQ_EN
        if (c_kind == REG_STATUS) bresp_d = OKAY;
`endif
      end
    end else if (s00_axi.bready) begin
      wr_state_d = W_IDLE;
    end
    if (commit && c_kind == REG_CTRL)
      for (int i = 0; i < NUM_CTRL; i++)
        if (c_idx == IDX_W'(i))
          for (int b = 0; b < DATA_W/8; b++)
            if (c_strb[b]) ctrl_d[i][b*8 +: 8] = c_data[b*8 +: 8];
  end

  // Read data is taken from current flops, so a same-edge write is not visible yet.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ar_rdy     = (rd_state_q == R_IDLE) && !s00_axi_areset;
    ar_fire    = s00_axi.arvalid && ar_rdy;
    r_idx      = s00_axi.araddr[ADDR_W-1:2];
    r_kind     = reg_kind(32'(r_idx), NUM_CTRL, NUM_CH);
    if (ar_fire) begin
      rd_state_d = R_DATA;
      rresp_d    = OKAY;
      rdata_d    = '0;
      case (r_kind)
        REG_CTRL:
          for (int i = 0; i < NUM_CTRL; i++)
            if (r_idx == IDX_W'(i)) rdata_d = ctrl_reg_q[i];
        REG_STATUS: rdata_d = status_word;
        REG_SAMPLE: rdata_d = rd_sample;
        default:    rresp_d = SLVERR;
      endcase
    end else if (rd_state_q == R_DATA && s00_axi.rready) begin
      rd_state_d = R_IDLE;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      ctrl_reg_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      ctrl_reg_q <= ctrl_d;
    end
  end

  assign s00_axi.awready = aw_rdy;
  assign s00_axi.wready  = w_rdy;
  assign s00_axi.bvalid  = (wr_state_q == W_RESP);
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = ar_rdy;
  assign s00_axi.rvalid  = (rd_state_q == R_DATA);
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;
  assign ctrl_q          = ctrl_reg_q;

  logic unused_addr;
  assign unused_addr = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

`ifdef GYRO_REGBANK_IRQ_EN
  assign irq_clr = commit && (c_kind == REG_STATUS) && c_strb[ST_IRQ_BIT/8] && c_data[ST_IRQ_BIT];
  assign irq     = irq_pend && ctrl_reg_q[0][1];
`else
  logic unused_irq_pend;
  assign unused_irq_pend = irq_pend;
  assign irq_clr = 1'b0;
  assign irq     = 1'b0;
`endif

  gyro_sample_latch #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_CTRL(NUM_CTRL), .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)
  ) u_latch (
    .clk         (s00_axi_aclk),
    .rst         (s00_axi_areset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .freeze      (ctrl_reg_q[0][0]),
    .rd_stb      (ar_fire),
    .rd_idx      (r_idx),
    .irq_clr     (irq_clr),
    .status_word (status_word),
    .rd_sample   (rd_sample),
    .irq_pend    (irq_pend)
  );

endmodule

// File: tb/tb_gyro_axil_regbank.sv
// Directed self-checking bench for gyro_axil_regbank (default 4 ctrl / 3 channel build).
module tb_gyro_axil_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [47:0] sample_data = '0;
  logic [127:0] ctrl_q;
  logic        irq;
  int          checks = 0;
  int          failures = 0;

`ifdef GYRO_REGBANK_IRQ_EN
  localparam logic [31:0] PEND = 32'h0002_0000;
`else
  localparam logic [31:0] PEND = 32'h0;
`endif

  always #5 clk = ~clk;

  gyro_axil_regbank_if #(.ADDR_W(8), .DATA_W(32)) axi ();

  gyro_axil_regbank #(
    .DATA_W(32), .ADDR_W(8), .NUM_CTRL(4), .NUM_CH(3), .SAMPLE_W(16)
  ) dut (
    .s00_axi_aclk  (clk),
    .s00_axi_areset(rst),
    .s00_axi       (axi),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .ctrl_q        (ctrl_q),
    .irq           (irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1; axi.bready = 1'b0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      tick();
      if (aw_hs) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; axi.wvalid = 1'b0; end
      n++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    while (!axi.bvalid && n < 20) begin tick(); n++; end
    if (!axi.bvalid) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h: bvalid never rose", a);
    end
    resp = axi.bresp;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs = 0;
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b0;
    while (!hs && n < 20) begin
      hs = axi.arvalid && axi.arready;
      tick();
      n++;
    end
    axi.arvalid = 1'b0;
    n = 0;
    while (!axi.rvalid && n < 20) begin tick(); n++; end
    if (!axi.rvalid) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h: rvalid never rose", a);
    end
    d = axi.rdata; resp = axi.rresp;
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
  endtask

  task automatic pulse_sample(input logic [47:0] d);
    sample_data = d; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, irq} !== 6'b0) begin
      failures++;
      $display("FAIL reset_hs: got %b want 000000",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, irq});
    end
    checks++;
    if ({axi.rdata, axi.rresp, axi.bresp} !== 36'h0) begin
      failures++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b", axi.rdata, axi.rresp, axi.bresp);
    end
    checks++;
    if (ctrl_q !== 128'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", ctrl_q); end
    rst = 1'b0;
    tick();
    checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      failures++; $display("FAIL ready_after_reset: got %b want 111", {axi.awready, axi.wready, axi.arready});
    end
  endtask

  task automatic test_regression();
    logic [1:0] r; logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(i*4), 32'(i+1), 4'hF, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL reg_wr%0d_resp: got %b want 00", i, r); end
    end
    checks++;
    if (ctrl_q !== 128'h00000004_00000003_00000002_00000001) begin
      failures++; $display("FAIL reg_ctrl_q: got %h", ctrl_q);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(i*4), d, r);
      checks++;
      if (d !== 32'(i+1) || r !== 2'b00) begin
        failures++; $display("FAIL reg_rd%0d: got %h/%b want %h/00", i, d, r, i+1);
      end
    end
  endtask

  task automatic test_wstrb_order();
    axi.wdata = 32'hAABBCCDD; axi.wstrb = 4'b0101; axi.wvalid = 1'b1; axi.bready = 1'b0;
    tick();
    axi.wvalid = 1'b0;
    checks++;
    if (axi.wready !== 1'b0 || axi.bvalid !== 1'b0) begin
      failures++; $display("FAIL w_held: wready=%b bvalid=%b want 0/0", axi.wready, axi.bvalid);
    end
    tick(); tick();
    checks++;
    if (axi.bvalid !== 1'b0) begin failures++; $display("FAIL early_bvalid: got %b want 0", axi.bvalid); end
    axi.awaddr = 8'h04; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
      failures++; $display("FAIL bvalid_after_aw: got %b/%b want 1/00", axi.bvalid, axi.bresp);
    end
    checks++;
    if (ctrl_q[63:32] !== 32'h00BB00DD) begin
      failures++; $display("FAIL wstrb_merge: got %h want 00bb00dd", ctrl_q[63:32]);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b0) begin failures++; $display("FAIL bvalid_drop: got %b want 0", axi.bvalid); end
  endtask

  task automatic test_samples();
    logic [1:0] r; logic [31:0] d;
    axi_write(8'h00, 32'h0, 4'hF, r);
    pulse_sample({16'h7FFF, 16'h1234, 16'h8001});
    axi_read(8'h14, d, r);
    checks++;
    if (d !== 32'hFFFF8001 || r !== 2'b00) begin failures++; $display("FAIL ch0_sext: got %h/%b want ffff8001/00", d, r); end
    axi_read(8'h18, d, r);
    checks++;
    if (d !== 32'h00001234) begin failures++; $display("FAIL ch1: got %h want 00001234", d); end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== (32'h1 | PEND)) begin failures++; $display("FAIL status_cnt1: got %h want %h", d, 32'h1 | PEND); end
    pulse_sample({16'h7FFF, 16'h1234, 16'h0005});
    axi_read(8'h10, d, r);
    checks++;
    if (d !== (32'h00010002 | PEND)) begin failures++; $display("FAIL overrun_set: got %h want %h", d, 32'h00010002 | PEND); end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== (32'h2 | PEND)) begin failures++; $display("FAIL overrun_clr: got %h want %h", d, 32'h2 | PEND); end
    axi_read(8'h14, d, r);
    checks++;
    if (d !== 32'h00000005) begin failures++; $display("FAIL ch0_update: got %h want 00000005", d); end
    axi_read(8'h1C, d, r);
    checks++;
    if (d !== 32'h00007FFF) begin failures++; $display("FAIL ch2: got %h want 00007fff", d); end
    pulse_sample({16'h7FFF, 16'h1234, 16'h0006});
    axi_read(8'h10, d, r);
    checks++;
    if (d !== (32'h3 | PEND)) begin failures++; $display("FAIL no_overrun: got %h want %h", d, 32'h3 | PEND); end
    axi_write(8'h00, 32'h1, 4'hF, r);
    pulse_sample({16'h2222, 16'h2222, 16'h1111});
    axi_read(8'h14, d, r);
    checks++;
    if (d !== 32'h00000006) begin failures++; $display("FAIL freeze_hold: got %h want 00000006", d); end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== (32'h00010004 | PEND)) begin failures++; $display("FAIL freeze_cnt: got %h want %h", d, 32'h00010004 | PEND); end
    axi_write(8'h00, 32'h0, 4'hF, r);
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [31:0] d;
    axi_write(8'hFC, 32'hFFFFFFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL oor_wr_resp: got %b want 10", r); end
`ifdef GYRO_REGBANK_IRQ_EN
    axi_write(8'h10, 32'h0, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL status_wr_resp: got %b want 00", r); end
`else
    axi_write(8'h10, 32'hFFFFFFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL status_wr_resp: got %b want 10", r); end
`endif
    checks++;
    if (ctrl_q !== 128'h00000004_00000003_00BB00DD_00000000) begin
      failures++; $display("FAIL err_no_change: got %h", ctrl_q);
    end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== (32'h4 | PEND)) begin failures++; $display("FAIL err_status: got %h want %h", d, 32'h4 | PEND); end
    axi_read(8'hFC, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL oor_rd: got %h/%b want 0/10", d, r); end
    axi.araddr = 8'h08; axi.arvalid = 1'b1; axi.rready = 1'b0;
    tick();
    axi.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h3 || axi.arready !== 1'b0) begin
        failures++;
        $display("FAIL r_hold%0d: rvalid=%b rdata=%h arready=%b want 1/3/0", i, axi.rvalid, axi.rdata, axi.arready);
      end
      tick();
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_drop: got %b want 0", axi.rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [31:0] d;
    axi.awaddr = 8'h0C; axi.awvalid = 1'b1;
    axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    axi.araddr = 8'h0C; axi.arvalid = 1'b1;
    axi.bready = 1'b0; axi.rready = 1'b0;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h4 || axi.bvalid !== 1'b1) begin
      failures++; $display("FAIL rd_wr_same: rvalid=%b rdata=%h bvalid=%b want 1/4/1", axi.rvalid, axi.rdata, axi.bvalid);
    end
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    axi_read(8'h0C, d, r);
    checks++;
    if (d !== 32'h55) begin failures++; $display("FAIL rd_after_wr: got %h want 00000055", d); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d;
    axi.awaddr = 8'h00; axi.awvalid = 1'b1;
    axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b1) begin failures++; $display("FAIL pre_reset_bvalid: got %b want 1", axi.bvalid); end
    rst = 1'b1;
    tick();
    checks++;
    if (axi.bvalid !== 1'b0 || ctrl_q !== 128'h0) begin
      failures++; $display("FAIL mid_reset: bvalid=%b ctrl_q=%h want 0/0", axi.bvalid, ctrl_q);
    end
    rst = 1'b0;
    tick();
    axi_read(8'h10, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_irq();
    logic [1:0] r; logic [31:0] d;
    axi_write(8'h00, 32'h2, 4'hF, r);
    pulse_sample(48'h0);
`ifdef GYRO_REGBANK_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b want 1", irq); end
    axi.awaddr = 8'h10; axi.awvalid = 1'b1;
    axi.wdata = 32'h00020000; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b0;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checks++;
    if (irq !== 1'b0 || axi.bresp !== 2'b00) begin
      failures++; $display("FAIL irq_w1c: irq=%b bresp=%b want 0/00", irq, axi.bresp);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    axi_read(8'h10, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL irq_status: got %h want 00000001", d); end
`else
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_tied: got %b want 0", irq); end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL irq_status: got %h want 00000001", d); end
    axi_write(8'h10, 32'h00020000, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL status_w1c_resp: got %b want 10", r); end
`endif
  endtask

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    test_reset();
    test_regression();
    test_wstrb_order();
    test_samples();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
